md_unit: RTL

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in stage E beside the ALU. It accepts one operation per start pulse and holds `busy` for a configurable number of cycles. It commits the result to HI/LO at a defined edge. An in-flight operation can be aborted by the exception/interrupt flush. The `busy`/`md_hazard` outputs feed the pause unit, which stalls md-class instructions in D.

---
 rtl/md_unit_if.sv | 38 +++
 rtl/md_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between stage E and the multiply/divide unit
//
// Purpose: groups the md_unit operation request, HI/LO write and flush inputs
//          with its status and HI/LO outputs.
// Signals:
//   start, op[1:0], a, b      operation launch and operands
//   wr_hi, wr_lo              mthi/mtlo writes (load from a)
//   cancel                    flush from exception/interrupt
//   busy, md_hazard, done     status towards the pause unit
//   hi, lo                    architectural HI/LO registers
// Modports: master drives requests (stage E / bench), slave is md_unit.

interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic             cancel;
    logic             busy;
    logic             md_hazard;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, cancel,
        input  busy, md_hazard, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, cancel,
        output busy, md_hazard, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: computes mult/multu/div/divu on launch, holds the result in
//          pending registers for a fixed latency, then commits it to HI/LO.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   md     slave modport of md_unit_if (request, writes, flush, status, HI/LO)
// Parameters: WIDTH (>=2), MULT_LAT (>=1), DIV_LAT (>=1).

module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] p_hi_q, p_lo_q;
    logic             p_ok_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;

    // Arithmetic is evaluated combinationally from the launch-cycle operands
    // and captured at the start edge; the latency is modelled by the counter.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   a_abs, b_abs, dvd, dvs, dvs_safe, q_u, r_u;
    logic               is_signed, b_zero;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_ok;

    assign prod_s = {{WIDTH{md.a[WIDTH-1]}}, md.a} * {{WIDTH{md.b[WIDTH-1]}}, md.b};
    assign prod_u = {{WIDTH{1'b0}}, md.a} * {{WIDTH{1'b0}}, md.b};

    assign is_signed = ~md.op[0];
    assign a_abs     = md.a[WIDTH-1] ? -md.a : md.a;
    assign b_abs     = md.b[WIDTH-1] ? -md.b : md.b;
    assign dvd       = is_signed ? a_abs : md.a;
    assign dvs       = is_signed ? b_abs : md.b;
    assign b_zero    = (md.b == '0);
    // Substitute a divisor of 1 on b=0 so the divider never produces X; the
    // result is discarded anyway via res_ok.
    assign dvs_safe  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : dvs;
    assign q_u       = dvd / dvs_safe;
    assign r_u       = dvd % dvs_safe;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_ok = 1'b1;
        case (md.op)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                // Magnitude division; -2^(W-1)/-1 yields 2^(W-1) which wraps
                // to the same bit pattern, so no overflow special case.
                res_lo = (md.a[WIDTH-1] ^ md.b[WIDTH-1]) ? -q_u : q_u;
                res_hi = md.a[WIDTH-1] ? -r_u : r_u;
                res_ok = ~b_zero;
            end
            default: begin
                res_lo = q_u;
                res_hi = r_u;
                res_ok = ~b_zero;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            p_ok_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md.cancel) begin
                        // flush blocks both launch and writes this cycle
                    end else if (md.start) begin
                        p_hi_q  <= res_hi;
                        p_lo_q  <= res_lo;
                        p_ok_q  <= res_ok;
                        cnt_q   <= md.op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        if (md.wr_hi) hi_q <= md.a;
                        if (md.wr_lo) lo_q <= md.a;
                    end
                end
                RUN: begin
                    if (md.cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            if (p_ok_q) begin
                                hi_q <= p_hi_q;
                                lo_q <= p_lo_q;
                            end
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md.busy      = busy_q;
    assign md.md_hazard = busy_q | md.start;
    assign md.done      = done_q;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
endmodule
